// File: rtl/mux16_scan_pkg.sv
// Shared constants for the 16:1 mux channel scanner.
//   NCH   - number of mux channels
//   SELW  - select width (log2 NCH)
//   CNTW  - dwell counter width (DWELL legal range 1..255)
//   IDLE / SETTLE / DONE - scanner state encoding
package mux16_scan_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;
  localparam int CNTW = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/mux16_next_chan.sv
// Combinational next-enabled-channel search.
//   mask_q [0:15] in  : enabled channels (bit i = channel i)
//   cur    [3:0]  in  : current channel
//   first         in  : 1 = search from channel 0 inclusive, 0 = strictly above cur
//   nxt    [3:0]  out : lowest qualifying enabled channel (0 when none)
//   found         out : a qualifying channel exists
// No wrap-around: channels at or below cur are never returned when first=0.
module mux16_next_chan
  import mux16_scan_pkg::*;
(
  input  logic [0:NCH-1]  mask_q,
  input  logic [SELW-1:0] cur,
  input  logic            first,
  output logic [SELW-1:0] nxt,
  output logic            found
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    // Walk downward so the lowest qualifying index is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (first || (i > int'(cur)))) begin
        nxt   = SELW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Sequential scanner for a 16:1 mux: steps the select over enabled channels,
// dwells DWELL cycles on each, samples f_in on the last dwell cycle and
// publishes the 16 samples atomically as result with a one-cycle done pulse.
//   Clock           in  : rising-edge clock
//   Resetn          in  : asynchronous active-low reset
//   start           in  : scan request, honoured only in IDLE
//   cont            in  : continuous mode, sampled in the DONE cycle
//   chan_mask [0:15] in : channel enables, latched at scan launch
//   f_in            in  : mux output
//   S        [3:0]  out : mux select
//   busy            out : scan in progress
//   done            out : one-cycle pulse, result updated
//   result   [0:15] out : sampled channels, masked channels read 0
module mux16_scan_ctrl
  import mux16_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            start,
  input  logic            cont,
  input  logic [0:NCH-1]  chan_mask,
  input  logic            f_in,
  output logic [SELW-1:0] S,
  output logic            busy,
  output logic            done,
  output logic [0:NCH-1]  result
);

  localparam logic [CNTW-1:0] DWELL_LOAD = CNTW'(DWELL - 1);

  logic [1:0]      state;
  logic [0:NCH-1]  mask_q;
  logic [0:NCH-1]  work_buf;
  logic [CNTW-1:0] cnt;

  logic [SELW-1:0] first_nxt, adv_nxt;
  logic            first_found, adv_found;
  logic [0:NCH-1]  buf_sampled;
  logic            launch;

  // First channel is searched in the live mask because it is latched on the
  // same edge that launches the scan.
  mux16_next_chan u_first (
    .mask_q (chan_mask),
    .cur    ('0),
    .first  (1'b1),
    .nxt    (first_nxt),
    .found  (first_found)
  );

  mux16_next_chan u_adv (
    .mask_q (mask_q),
    .cur    (S),
    .first  (1'b0),
    .nxt    (adv_nxt),
    .found  (adv_found)
  );

  // Working buffer with the current channel's sample merged in; this is what
  // gets stored (and possibly published) on the sample edge.
  always_comb begin
    buf_sampled    = work_buf;
    buf_sampled[S] = f_in;
  end

  // A scan launches from IDLE on start, or back-to-back from DONE in
  // continuous mode; start is deliberately ignored in DONE.
  assign launch = ((state == IDLE) && start) || ((state == DONE) && cont);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      S        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      work_buf <= '0;
      mask_q   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        mask_q   <= chan_mask;
        work_buf <= '0;
        if (first_found) begin
          state <= SETTLE;
          S     <= first_nxt;
          cnt   <= DWELL_LOAD;
          busy  <= 1'b1;
        end else begin
          // Empty mask: report an all-zero result straight away.
          state  <= DONE;
          S      <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= '0;
        end
      end else begin
        case (state)
          SETTLE: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              work_buf <= buf_sampled;
              if (adv_found) begin
                S   <= adv_nxt;
                cnt <= DWELL_LOAD;
              end else begin
                state  <= DONE;
                S      <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= buf_sampled;
              end
            end
          end
          default: begin
            // IDLE without start, DONE without cont, or an unused encoding.
            state <= IDLE;
            S     <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Scoreboard bench for mux16_scan_ctrl. Three instances with DWELL = 2, 3, 1
// share clock, reset, cont and chan_mask; each has its own start and its own
// mux model (f_in = w[S]). Stimulus pushes {expected done cycle, result};
// a negedge monitor pops and compares whenever an instance pulses done.
module tb_mux16_scan_ctrl;

  typedef struct {
    int          cyc;
    logic [0:15] res;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        cont;
  logic [0:15] chan_mask;

  logic        start_v [3];
  logic        f_v     [3];
  logic [3:0]  s_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [0:15] res_v   [3];
  logic [0:15] w_v     [3];

  exp_t exp_q [3][$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign f_v[0] = w_v[0][s_v[0]];
  assign f_v[1] = w_v[1][s_v[1]];
  assign f_v[2] = w_v[2][s_v[2]];

  mux16_scan_ctrl #(.DWELL(2)) u_d2 (
    .Clock(Clock), .Resetn(Resetn), .start(start_v[0]), .cont(cont),
    .chan_mask(chan_mask), .f_in(f_v[0]), .S(s_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(res_v[0]));

  mux16_scan_ctrl #(.DWELL(3)) u_d3 (
    .Clock(Clock), .Resetn(Resetn), .start(start_v[1]), .cont(cont),
    .chan_mask(chan_mask), .f_in(f_v[1]), .S(s_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(res_v[1]));

  mux16_scan_ctrl #(.DWELL(1)) u_d1 (
    .Clock(Clock), .Resetn(Resetn), .start(start_v[2]), .cont(cont),
    .chan_mask(chan_mask), .f_in(f_v[2]), .S(s_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .result(res_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the head of its instance's queue, and an
  // expectation whose cycle has passed without a done is a missing pulse.
  always @(negedge Clock) begin
    if (Resetn) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_done%0d", i), 32'(done_v[i]), 32'd0);
          end else begin
            exp_t e;
            e = exp_q[i].pop_front();
            check($sformatf("done%0d_cycle", i), cyc, e.cyc);
            check($sformatf("done%0d_result", i), 32'(res_v[i]), 32'(e.res));
          end
        end else if (exp_q[i].size() != 0 && cyc > exp_q[i][0].cyc) begin
          check($sformatf("missing_done%0d", i), 32'd0, 32'd1);
          void'(exp_q[i].pop_front());
        end
      end
    end
  end

  // Pulse start on one instance; t is the edge that samples it. Expected done
  // lands n_en*dwell cycles after t in monitor cycle numbering.
  task automatic issue(input int inst, input logic [0:15] m, input int n_en,
                       input int dwell, input logic [0:15] res, input bit push,
                       output int t);
    exp_t e;
    @(negedge Clock);
    chan_mask     = m;
    start_v[inst] = 1'b1;
    t = cyc + 1;
    if (push) begin
      e.cyc = t + n_en * dwell;
      e.res = res;
      exp_q[inst].push_back(e);
    end
    @(negedge Clock);
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < budget) begin
      @(negedge Clock);
      k++;
    end
    check("drain_timeout", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    exp_q[0].delete(); exp_q[1].delete(); exp_q[2].delete();
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   t;
    exp_t e;
    Resetn    = 1'b0;
    cont      = 1'b0;
    chan_mask = '0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      w_v[i]     = '0;
    end
    #12;
    check("rst_S", 32'(s_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_result", 32'(res_v[0]), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    // Empty mask: done one cycle after start, never busy.
    issue(0, 16'h0000, 0, 2, 16'h0000, 1'b1, t);
    check("empty_busy", 32'(busy_v[0]), 32'd0);
    drain(10);

    // Full mask, DWELL=2: select walks 0..15 every 2 cycles.
    w_v[0] = 16'hA5C3;
    issue(0, 16'hFFFF, 16, 2, 16'hA5C3, 1'b1, t);
    check("full_busy_first", 32'(busy_v[0]), 32'd1);
    for (int k = 0; k < 16; k++) begin
      wait_cyc(t + 2 * k);
      check($sformatf("full_S_ch%0d", k), 32'(s_v[0]), k);
    end
    wait_cyc(t + 31);
    check("full_busy_last", 32'(busy_v[0]), 32'd1);
    check("full_result_stable", 32'(res_v[0]), 32'd0);
    wait_cyc(t + 32);
    check("full_busy_done", 32'(busy_v[0]), 32'd0);
    drain(60);

    // Sparse mask 0/15, DWELL=3: only two channels visited.
    w_v[1] = 16'hFFFF;
    issue(1, 16'h8001, 2, 3, 16'h8001, 1'b1, t);
    wait_cyc(t + 2);
    check("sparse_S0", 32'(s_v[1]), 32'd0);
    wait_cyc(t + 3);
    check("sparse_S15", 32'(s_v[1]), 32'd15);
    drain(20);

    // Continuous, DWELL=1: mux data changes at channel 8 of the first scan.
    w_v[2] = 16'h1234;
    cont   = 1'b1;
    issue(2, 16'hFFFF, 16, 1, 16'h1221, 1'b1, t);
    e.cyc = t + 33;
    e.res = 16'h4321;
    exp_q[2].push_back(e);
    wait_cyc(t + 8);
    check("cont_S8", 32'(s_v[2]), 32'd8);
    w_v[2] = 16'h4321;
    wait_cyc(t + 20);
    cont = 1'b0;
    drain(60);
    repeat (20) @(negedge Clock);

    // Reset at channel 5 aborts the scan with no done pulse.
    w_v[0] = 16'hA5C3;
    issue(0, 16'hFFFF, 16, 2, 16'h0000, 1'b0, t);
    wait_cyc(t + 10);
    check("abort_S5", 32'(s_v[0]), 32'd5);
    Resetn = 1'b0;
    #1;
    check("abort_S", 32'(s_v[0]), 32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_result", 32'(res_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    issue(0, 16'hFFFF, 16, 2, 16'hA5C3, 1'b1, t);
    drain(60);

    // start held through a scan and mask changed mid-scan.
    w_v[0] = 16'h5A5A;
    @(negedge Clock);
    chan_mask  = 16'hFFFF;
    start_v[0] = 1'b1;
    t = cyc + 1;
    e.cyc = t + 32;
    e.res = 16'h5A5A;
    exp_q[0].push_back(e);
    e.cyc = t + 34 + 16;
    e.res = 16'h0A0A;
    exp_q[0].push_back(e);
    wait_cyc(t + 10);
    chan_mask = 16'h0F0F;
    wait_cyc(t + 12);
    check("hold_busy", 32'(busy_v[0]), 32'd1);
    check("hold_S6", 32'(s_v[0]), 32'd6);
    wait_cyc(t + 33);
    check("hold_idle_busy", 32'(busy_v[0]), 32'd0);
    wait_cyc(t + 34);
    start_v[0] = 1'b0;
    check("hold_restart_S", 32'(s_v[0]), 32'd4);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
